// File: rtl/lc3_dp_pkg.sv
// Shared types and helpers for the parametrised LC-3 datapath:
// mux/ALU encodings, memory-handshake FSM states and a sign-extension helper.
package lc3_dp_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_AND  = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_PASS = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_INC   = 2'b00,
        PC_BUS   = 2'b01,
        PC_ADDER = 2'b10,
        PC_HOLD  = 2'b11
    } pcmux_e;

    typedef enum logic [1:0] {
        OFF_ZERO = 2'b00,
        OFF_6    = 2'b01,
        OFF_9    = 2'b10,
        OFF_11   = 2'b11
    } addr2mux_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Replicates value[from_bit] into every bit above it, up to bit w-1; bits >= w are zero.
    function automatic logic [63:0] sext(input logic [63:0] value, input int from_bit, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i >= w)
                r[i] = 1'b0;
            else if (i <= from_bit)
                r[i] = value[i];
            else
                r[i] = value[6'(from_bit)];
        end
        return r;
    endfunction

endpackage

// File: rtl/lc3_reg_file.sv
// NREGS x W register file: two combinational read ports, one synchronous write port.
// Reads of the register being written return the pre-write value.
module lc3_reg_file
    import lc3_dp_pkg::*;
#(
    parameter int W     = 16,
    parameter int NREGS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(NREGS)-1:0] raddr1,
    input  logic [$clog2(NREGS)-1:0] raddr2,
    output logic [W-1:0]             rdata1,
    output logic [W-1:0]             rdata2
);

    logic [W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/lc3_datapath_param.sv
// Parametrised LC-3 datapath around one shared bus, with a request/ack memory port.
// Optional BUS_CONFLICT_CHECK_EN builds the sticky multi-gate detector behind bus_err.
module lc3_datapath_param
    import lc3_dp_pkg::*;
#(
    parameter int           W        = 16,
    parameter int           NREGS    = 8,
    parameter logic [W-1:0] PC_RESET = '0
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     gateMARMUX,
    input  logic                     gatePC,
    input  logic                     gateALU,
    input  logic                     gateMDR,
    input  logic                     LD_PC,
    input  logic                     LD_IR,
    input  logic                     LD_MAR,
    input  logic                     LD_MDR,
    input  logic                     LD_REG,
    input  logic                     LD_CC,
    input  logic [1:0]               PCMUX,
    input  logic                     ADDR1MUX,
    input  logic [1:0]               ADDR2MUX,
    input  logic                     MARMUX,
    input  logic [$clog2(NREGS)-1:0] DR,
    input  logic [$clog2(NREGS)-1:0] SR1,
    input  logic [$clog2(NREGS)-1:0] SR2,
    input  logic                     SR2MUX,
    input  logic [1:0]               ALUK,
    input  logic                     MIO_EN,
    input  logic                     mem_rd,
    input  logic                     mem_wr,
    input  logic                     mem_ack,
    input  logic [W-1:0]             mem_rdata,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [W-1:0]             mem_addr,
    output logic [W-1:0]             mem_wdata,
    output logic                     mem_busy,
    output logic [W-1:0]             IR,
    output logic [W-1:0]             PC,
    output logic [2:0]               nzp,
    output logic                     bus_err
);

    logic [W-1:0]        mar, mdr, bus, alu_out, marmux_out;
    logic [W-1:0]        sr1_data, sr2_data;
    logic signed [W-1:0] addr1, addr2, adder_out, alu_a, alu_b;
    mem_state_e          state, state_next;
    logic                mem_start, mem_done;

    function automatic logic [2:0] cc_of(input logic [W-1:0] v);
        if (v[W-1])
            return 3'b100;
        else if (v == '0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    lc3_reg_file #(.W(W), .NREGS(NREGS)) u_reg_file (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .we     (LD_REG),
        .waddr  (DR),
        .wdata  (bus),
        .raddr1 (SR1),
        .raddr2 (SR2),
        .rdata1 (sr1_data),
        .rdata2 (sr2_data)
    );

    always_comb begin
        addr1 = ADDR1MUX ? sr1_data : PC;
        case (addr2mux_e'(ADDR2MUX))
            OFF_6:   addr2 = W'(sext(64'(IR), 5, W));
            OFF_9:   addr2 = W'(sext(64'(IR), 8, W));
            OFF_11:  addr2 = W'(sext(64'(IR), 10, W));
            default: addr2 = '0;
        endcase
        adder_out  = addr1 + addr2;
        marmux_out = MARMUX ? adder_out : {{(W-8){1'b0}}, IR[7:0]};
    end

    always_comb begin
        alu_a = sr1_data;
        alu_b = SR2MUX ? W'(sext(64'(IR), 4, W)) : sr2_data;
        case (alu_op_e'(ALUK))
            ALU_ADD: alu_out = alu_a + alu_b;
            ALU_AND: alu_out = alu_a & alu_b;
            ALU_NOT: alu_out = ~alu_a;
            default: alu_out = alu_a;
        endcase
    end

    // Fixed-priority bus; an undriven bus reads as zero.
    always_comb begin
        bus = '0;
        if (gateMARMUX)
            bus = marmux_out;
        else if (gatePC)
            bus = PC;
        else if (gateALU)
            bus = alu_out;
        else if (gateMDR)
            bus = mdr;
    end

    always_comb begin
        state_next = state;
        mem_start  = 1'b0;
        mem_done   = 1'b0;
        mem_req    = 1'b0;
        mem_busy   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_rd ^ mem_wr) begin
                    mem_start  = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                mem_req  = 1'b1;
                mem_busy = 1'b1;
                if (mem_ack) begin
                    mem_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            state <= state_next;
            if (mem_start) begin
                mem_addr  <= mar;
                mem_wdata <= mdr;
                mem_we    <= mem_wr;
            end else if (mem_done) begin
                mem_we <= 1'b0;
            end
        end
    end

    // MAR and MDR are frozen while a request is in flight so the request stays stable.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            PC  <= PC_RESET;
            IR  <= '0;
            mar <= '0;
            mdr <= '0;
            nzp <= 3'b010;
        end else begin
            if (LD_PC) begin
                case (pcmux_e'(PCMUX))
                    PC_INC:   PC <= PC + W'(1);
                    PC_BUS:   PC <= bus;
                    PC_ADDER: PC <= adder_out;
                    default:  PC <= PC;
                endcase
            end
            if (LD_IR)
                IR <= bus;
            if (LD_MAR && state == IDLE)
                mar <= bus;
            if (mem_done && !mem_we)
                mdr <= mem_rdata;
            else if (LD_MDR && !MIO_EN && state == IDLE)
                mdr <= bus;
            if (LD_CC)
                nzp <= cc_of(bus);
        end
    end

`ifdef BUS_CONFLICT_CHECK_EN
    logic multi_gate;
    assign multi_gate = $countones({gateMARMUX, gatePC, gateALU, gateMDR}) > 1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            bus_err <= 1'b0;
        else if (multi_gate)
            bus_err <= 1'b1;
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule
